// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional s[i]=i fill, then a 4-cycle-per-byte shuffle
// against an external synchronous-read RAM (read data one cycle after the address).
module rc4_ksa_engine #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int MAX_KEY_BYTES = 16,
  parameter int INIT_EN       = 1,
  localparam int KL_W         = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   start_i,
  input  logic                                   abort_i,
  input  logic [KL_W-1:0]                        key_len_i,
  input  logic [MAX_KEY_BYTES-1:0][DATA_W-1:0]   key_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   err_o,
  output logic [ADDR_W-1:0]                      ram_addr_o,
  output logic [DATA_W-1:0]                      ram_wdata_o,
  output logic                                   ram_we_o,
  input  logic [DATA_W-1:0]                      ram_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RD_I, S_CAP_I, S_CAP_J, S_WR_J, S_DONE
  } state_t;

  state_t                               state_q, state_d;
  logic [ADDR_W-1:0]                    i_q, i_d;
  logic [ADDR_W-1:0]                    j_q, j_d;
  logic [KL_W-1:0]                      kidx_q, kidx_d;
  logic [DATA_W-1:0]                    si_q, si_d;
  logic [KL_W-1:0]                      key_len_q, key_len_d;
  logic [MAX_KEY_BYTES-1:0][DATA_W-1:0] key_q, key_d;
  logic                                 err_q, err_d;

  logic [DATA_W-1:0] key_sel;
  logic [ADDR_W-1:0] j_new;
  logic              len_ok;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      kidx_q    <= '0;
      si_q      <= '0;
      key_len_q <= '0;
      key_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      kidx_q    <= kidx_d;
      si_q      <= si_d;
      key_len_q <= key_len_d;
      key_q     <= key_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    kidx_d      = kidx_q;
    si_d        = si_q;
    key_len_d   = key_len_q;
    key_d       = key_q;
    err_d       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;

    // Mux instead of a direct index: kidx is one bit wider than the key array needs.
    key_sel = '0;
    for (int k = 0; k < MAX_KEY_BYTES; k++) begin
      if (kidx_q == KL_W'(k)) key_sel = key_q[k];
    end
    j_new  = j_q + ram_rdata_i[ADDR_W-1:0] + key_sel[ADDR_W-1:0];
    len_ok = (key_len_i != '0) && (key_len_i <= KL_W'(MAX_KEY_BYTES));

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_ok) begin
            key_d     = key_i;
            key_len_d = key_len_i;
            i_d       = '0;
            j_d       = '0;
            kidx_d    = '0;
            state_d   = (INIT_EN != 0) ? S_INIT : S_RD_I;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_INIT: begin
        busy_o      = 1'b1;
        ram_addr_o  = i_q;
        ram_wdata_o = DATA_W'(i_q);
        ram_we_o    = 1'b1;
        i_d         = i_q + ADDR_W'(1);
        if (&i_q) state_d = S_RD_I;
      end
      S_RD_I: begin
        busy_o     = 1'b1;
        ram_addr_o = i_q;
        state_d    = S_CAP_I;
      end
      S_CAP_I: begin
        busy_o     = 1'b1;
        si_d       = ram_rdata_i;
        j_d        = j_new;
        ram_addr_o = j_new;
        state_d    = S_CAP_J;
      end
      S_CAP_J: begin
        // s[j] is forwarded straight from the RAM into the write to s[i].
        busy_o      = 1'b1;
        ram_addr_o  = i_q;
        ram_wdata_o = ram_rdata_i;
        ram_we_o    = 1'b1;
        state_d     = S_WR_J;
      end
      S_WR_J: begin
        busy_o      = 1'b1;
        ram_addr_o  = j_q;
        ram_wdata_o = si_q;
        ram_we_o    = 1'b1;
        kidx_d      = (kidx_q == key_len_q - KL_W'(1)) ? '0 : kidx_q + KL_W'(1);
        if (&i_q) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          state_d = S_RD_I;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (busy_o && abort_i) state_d = S_IDLE;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: a 4-entry instance (hand vectors, abort/reset corners)
// and a 256-entry instance (software KSA model, random keys, abort mid-shuffle).
module tb_rc4_ksa_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0;
  logic sel = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] key_len = '0;
  logic [15:0][7:0] key_tb = '0;

  logic [3:0][1:0] key_a;
  logic busy_a, done_a, err_a, we_a, busy_b, done_b, err_b, we_b;
  logic [1:0] addr_a, wdata_a, rdata_a;
  logic [7:0] addr_b, wdata_b, rdata_b;
  logic [1:0] mem_a [4];
  logic [7:0] mem_b [256];

  always_comb begin
    key_a = '0;
    for (int i = 0; i < 4; i++) key_a[i] = key_tb[i][1:0];
  end

  rc4_ksa_engine #(.DATA_W(2), .ADDR_W(2), .MAX_KEY_BYTES(4), .INIT_EN(1)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .start_i(start & ~sel), .abort_i(abort & ~sel),
    .key_len_i(key_len[2:0]), .key_i(key_a), .busy_o(busy_a), .done_o(done_a),
    .err_o(err_a), .ram_addr_o(addr_a), .ram_wdata_o(wdata_a), .ram_we_o(we_a),
    .ram_rdata_i(rdata_a));

  rc4_ksa_engine #(.DATA_W(8), .ADDR_W(8), .MAX_KEY_BYTES(16), .INIT_EN(1)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .start_i(start & sel), .abort_i(abort & sel),
    .key_len_i(key_len[4:0]), .key_i(key_tb), .busy_o(busy_b), .done_o(done_b),
    .err_o(err_b), .ram_addr_o(addr_b), .ram_wdata_o(wdata_b), .ram_we_o(we_b),
    .ram_rdata_i(rdata_b));

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= wdata_a;
    rdata_a <= mem_a[addr_a];
    if (we_b) mem_b[addr_b] <= wdata_b;
    rdata_b <= mem_b[addr_b];
  end

  wire busy_s = sel ? busy_b : busy_a;
  wire done_s = sel ? done_b : done_a;
  wire err_s  = sel ? err_b  : err_a;
  wire we_s   = sel ? we_b   : we_a;
  wire [7:0] addr_s  = sel ? addr_b  : {6'd0, addr_a};
  wire [7:0] wdata_s = sel ? wdata_b : {6'd0, wdata_a};

  int wa[$];
  int wd[$];
  always @(posedge clk) begin
    if (we_s) begin
      wa.push_back(int'(addr_s));
      wd.push_back(int'(wdata_s));
    end
  end

  int checks = 0, failures = 0;
  int ms[256];
  int mj[256];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference KSA straight from the algorithm; key bytes are reduced mod n.
  task automatic ref_ksa(input int n, input int len);
    int j, t;
    j = 0;
    for (int i = 0; i < n; i++) ms[i] = i;
    for (int i = 0; i < n; i++) begin
      j = (j + ms[i] + (int'(key_tb[i % len]) % n)) % n;
      mj[i] = j;
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
    end
  endtask

  function automatic int ram_bad(input bit s, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if ((s ? int'(mem_b[i]) : int'(mem_a[i])) != ms[i]) bad++;
    end
    return bad;
  endfunction

  // Launch: start sampled on the next edge (edge k); returns at the negedge of cycle k+1.
  task automatic start_op(input bit s, input int len);
    @(negedge clk);
    sel = s;
    key_len = 8'(len);
    ref_ksa(s ? 256 : 4, len);
    wa.delete(); wd.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Key inputs are scrambled and start re-pulsed mid-run; neither may disturb the operation.
  task automatic wait_done(output int lat, output int bcnt, output int fb, output int errs);
    int n;
    lat = -1; bcnt = 0; errs = 0; fb = int'(busy_s); n = 1;
    while (n < 3000) begin
      if (busy_s) bcnt++;
      if (err_s) errs++;
      if (done_s) begin lat = n; break; end
      if (n == 3) begin
        start = 1'b1;
        key_len = 8'($urandom_range(0, 20));
        for (int i = 0; i < 16; i++) key_tb[i] = 8'($urandom);
      end
      if (n == 4) start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic err_test(input bit s, input int len, input string name);
    @(negedge clk);
    sel = s; key_len = 8'(len);
    wa.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_err_pulse"}, int'(err_s), 1);
    chk({name, "_busy"}, int'(busy_s), 0);
    @(negedge clk);
    chk({name, "_err_clear"}, int'(err_s), 0);
    chk({name, "_no_write"}, wa.size(), 0);
  endtask

  task automatic full_run(input bit s, input string name);
    int lat, bcnt, fb, errs, n, bad;
    n = s ? 256 : 4;
    wait_done(lat, bcnt, fb, errs);
    chk({name, "_busy_rise"}, fb, 1);
    chk({name, "_done_lat"}, lat, 1 + 5 * n);
    chk({name, "_busy_cycles"}, bcnt, 4 * n + n);
    chk({name, "_no_err"}, errs, 0);
    bad = 0;
    for (int i = 0; i < n; i++) if (i >= wa.size() || wa[i] != i || wd[i] != i) bad++;
    chk({name, "_init_writes"}, bad, 0);
    chk({name, "_write_count"}, wa.size(), 3 * n);
    chk({name, "_ram_vs_model"}, ram_bad(s, n), 0);
    @(negedge clk);
    chk({name, "_done_1cyc"}, int'(done_s) + int'(busy_s), 0);
  endtask

  typedef struct {
    int len;
    int k[4];
    int exp[4];
  } vec_t;
  vec_t vt[3];

  initial begin
    int donecnt, bad, len;
    vt[0] = '{len: 1, k: '{0, 0, 0, 0}, exp: '{0, 2, 3, 1}};
    vt[1] = '{len: 2, k: '{1, 2, 0, 0}, exp: '{0, 3, 2, 1}};
    vt[2] = '{len: 3, k: '{3, 1, 2, 0}, exp: '{0, 2, 1, 3}};

    #1 rst_a = 1'b1; rst_b = 1'b1;
    #1;
    chk("reset_a_outs", int'({busy_a, done_a, err_a, we_a, addr_a, wdata_a}), 0);
    chk("reset_b_outs", int'({busy_b, done_b, err_b, we_b, addr_b, wdata_b}), 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    for (int v = 0; v < 3; v++) begin
      key_tb = '0;
      for (int i = 0; i < 4; i++) key_tb[i] = 8'(vt[v].k[i]);
      start_op(1'b0, vt[v].len);
      full_run(1'b0, $sformatf("vec%0d", v));
      for (int i = 0; i < 4; i++)
        chk($sformatf("vec%0d_s%0d", v, i), int'(mem_a[i]), vt[v].exp[i]);
    end

    err_test(1'b0, 0, "a_len0");
    err_test(1'b0, 5, "a_len5");
    err_test(1'b1, 0, "b_len0");
    err_test(1'b1, 17, "b_len17");

    key_tb = '0;
    key_tb[0] = 8'h4B; key_tb[1] = 8'h65; key_tb[2] = 8'h79;
    start_op(1'b1, 3);
    full_run(1'b1, "key_str");

    for (int r = 0; r < 2; r++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) key_tb[i] = 8'($urandom);
      start_op(1'b1, len);
      full_run(1'b1, $sformatf("rand%0d", r));
    end

    // Abort during WR_J of i=5: INIT fills cycles 1..256, iteration i ends at 260+4i.
    for (int i = 0; i < 16; i++) key_tb[i] = 8'($urandom);
    start_op(1'b1, $urandom_range(1, 16));
    donecnt = 0;
    for (int n = 1; n < 280; n++) begin
      if (done_s) donecnt++;
      if (n == 3) start = 1'b1;
      if (n == 4) start = 1'b0;
      @(negedge clk);
    end
    chk("abort_wrj_we", int'(we_s), 1);
    chk("abort_wrj_addr", int'(addr_s), mj[5]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", int'(busy_s) + int'(we_s), 0);
    repeat (6) begin
      if (done_s || busy_s) donecnt++;
      @(negedge clk);
    end
    chk("abort_no_done", donecnt, 0);
    len = $urandom_range(1, 16);
    for (int i = 0; i < 16; i++) key_tb[i] = 8'($urandom);
    start_op(1'b1, len);
    full_run(1'b1, "post_abort");

    // Asynchronous reset mid-shuffle, asserted between clock edges.
    key_tb = '0;
    start_op(1'b0, 1);
    repeat (9) @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("rst_async_outs", int'({busy_a, done_a, err_a, we_a, addr_a, wdata_a}), 0);
    @(negedge clk);
    chk("rst_hold_outs", int'({busy_a, done_a, err_a, we_a, addr_a, wdata_a}), 0);
    rst_a = 1'b0;
    start_op(1'b0, 1);
    full_run(1'b0, "post_reset");
    bad = 0;
    for (int i = 0; i < 4; i++) if (int'(mem_a[i]) != vt[0].exp[i]) bad++;
    chk("post_reset_vec0", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_engine.md
RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

Interface
REQ-001 Parameter DATA_W, default 8, RAM word width in bits.
REQ-002 Parameter ADDR_W, default 8, RAM address width; state array depth N = 2^ADDR_W; DATA_W >= ADDR_W SHALL hold.
REQ-003 Parameter MAX_KEY_BYTES, default 16, maximum runtime key length.
REQ-004 Parameter INIT_EN, default 1: 1 = engine fills s[i]=i before shuffling; 0 = RAM is already initialised.
REQ-005 clk  input  1  single clock, all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request; accepted only in IDLE.
REQ-008 abort  input  1  synchronous cancel of a running operation.
REQ-009 key_len  input  $clog2(MAX_KEY_BYTES+1)  key length in bytes, valid range 1..MAX_KEY_BYTES.
REQ-010 key  input  MAX_KEY_BYTES x DATA_W  key bytes; key[0] is used at i=0.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse on successful completion.
REQ-013 err  output  1  one-cycle pulse on start with an illegal key_len.
REQ-014 ram_addr  output  ADDR_W  RAM address.
REQ-015 ram_wdata  output  DATA_W  RAM write data.
REQ-016 ram_we  output  1  RAM write enable.
REQ-017 ram_rdata  input  DATA_W  RAM read data, valid exactly one cycle after ram_addr is presented (synchronous read).

Function
REQ-018 States SHALL be IDLE, INIT, RD_I, CAP_I, CAP_J, WR_J and DONE.
REQ-019 IDLE: start with a legal key_len SHALL latch key and key_len into internal registers, clear i, j and kidx, and go to INIT if INIT_EN=1, else to RD_I.
REQ-020 IDLE: start with key_len=0 or key_len>MAX_KEY_BYTES SHALL pulse err for the next cycle and remain in IDLE with no RAM write.
REQ-021 INIT: each cycle SHALL drive ram_addr=i, ram_wdata=i zero-extended to DATA_W and ram_we=1, then increment i; after i=N-1, i SHALL wrap to 0 and the state SHALL advance to RD_I.
REQ-022 RD_I: SHALL drive ram_addr=i with ram_we=0.
REQ-023 CAP_I: SHALL capture si=ram_rdata, compute j=(j+si+key[kidx]) mod N (operands truncated to ADDR_W) and drive ram_addr=new j with ram_we=0.
REQ-024 CAP_J: SHALL capture sj=ram_rdata and drive ram_addr=i, ram_wdata=sj, ram_we=1.
REQ-025 WR_J: SHALL drive ram_addr=j, ram_wdata=si, ram_we=1; kidx SHALL become 0 if kidx=key_len-1, else kidx+1, with no divider or modulo operator; if i<N-1, i SHALL increment and the state SHALL go to RD_I, else go to DONE.
REQ-026 Each shuffle iteration SHALL take exactly 4 cycles.
REQ-027 DONE: SHALL hold for one cycle with done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in INIT, RD_I, CAP_I, CAP_J and WR_J, and 0 in IDLE and DONE.
REQ-029 Latency: for start accepted at edge k, busy SHALL rise at cycle k+1 and done SHALL pulse at cycle k+1+INIT_EN*N+4N.
REQ-030 When i=j, both writes SHALL still occur at the same address, leaving s[i] unchanged.
REQ-031 start asserted while not in IDLE SHALL be ignored, with no restart and no err.
REQ-032 abort in any busy state SHALL move the state to IDLE at the next edge with ram_we=0 from that cycle; done SHALL NOT pulse, and RAM contents are undefined afterwards.
REQ-033 Changes on key or key_len during an operation SHALL have no effect.
REQ-034 In IDLE, ram_we SHALL be 0 and ram_addr and ram_wdata SHALL be 0.

Reset
REQ-035 While reset=1, the state SHALL be IDLE, i, j, kidx, si and sj SHALL be 0, and busy, done, err, ram_we, ram_addr and ram_wdata SHALL be 0, asynchronously and without waiting for a clock edge.
REQ-036 Reset asserted mid-operation SHALL terminate the operation; after release the block SHALL accept a new start normally.

Verification
REQ-037 ADDR_W=2, DATA_W=2, INIT_EN=1, key_len=1, key[0]=0, start at edge k -> 4 INIT writes of 0..3; final RAM [0,2,3,1]; done pulse at k+21; covers the i=j write case and j wrap.
REQ-038 Same parameters, key_len=2, key={1,2} -> final RAM [0,3,2,1]; covers kidx wrap.
REQ-039 ADDR_W=8, key_len=3, key={0x4B,0x65,0x79} -> final RAM matches the software KSA model for "Key"; done at k+1281; busy high for exactly 1280 cycles.
REQ-040 key_len=0, then key_len=MAX_KEY_BYTES+1 -> err pulses for one cycle each; busy stays 0; ram_we stays 0.
REQ-041 Start again while busy -> ignored; abort at WR_J of i=5 -> IDLE next cycle, ram_we=0, no done; a later start completes correctly.
REQ-042 Assert reset between clock edges mid-shuffle -> all outputs read 0 immediately; after release, a fresh start reproduces the REQ-037 result.
